// File: rtl/vrf_wb_queue_if.sv
`default_nettype none
// ============================================================================
// Module  : vrf_wb_queue_if
// Brief   : FU write-back channels and regfile write ports seen by vrf_wb_queue
// Rev     : 1.0  initial release
// ============================================================================
interface vrf_wb_queue_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16
);
  logic                  fu0_vld;
  logic                  fu0_rdy;
  logic [ADDR_WIDTH-1:0] fu0_waddr;
  logic [DATA_WIDTH-1:0] fu0_wmask;
  logic [DATA_WIDTH-1:0] fu0_wdata;
  logic                  fu1_vld;
  logic                  fu1_rdy;
  logic [ADDR_WIDTH-1:0] fu1_waddr;
  logic [DATA_WIDTH-1:0] fu1_wmask;
  logic [DATA_WIDTH-1:0] fu1_wdata;

  logic                  wr0_vld;
  logic                  wr0_conflict;
  logic [ADDR_WIDTH-1:0] waddr0;
  logic [DATA_WIDTH-1:0] wmask0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  wr1_vld;
  logic                  wr1_conflict;
  logic [ADDR_WIDTH-1:0] waddr1;
  logic [DATA_WIDTH-1:0] wmask1;
  logic [DATA_WIDTH-1:0] wdata1;

  logic [1:0]            starve_hold;
  logic                  idle;

  // master: the write-back queue (initiator of regfile writes)
  modport master (
    input  fu0_vld, fu0_waddr, fu0_wmask, fu0_wdata,
    input  fu1_vld, fu1_waddr, fu1_wmask, fu1_wdata,
    output fu0_rdy, fu1_rdy,
    output wr0_vld, waddr0, wmask0, wdata0,
    output wr1_vld, waddr1, wmask1, wdata1,
    input  wr0_conflict, wr1_conflict,
    output starve_hold, idle
  );

  modport slave (
    output fu0_vld, fu0_waddr, fu0_wmask, fu0_wdata,
    output fu1_vld, fu1_waddr, fu1_wmask, fu1_wdata,
    input  fu0_rdy, fu1_rdy,
    input  wr0_vld, waddr0, wmask0, wdata0,
    input  wr1_vld, waddr1, wmask1, wdata1,
    output wr0_conflict, wr1_conflict,
    input  starve_hold, idle
  );
endinterface
`default_nettype wire

// File: rtl/vrf_wb_queue.sv
`default_nettype none
// ============================================================================
// Module  : vrf_wb_queue
// Brief   : Two-channel VRF write-back FIFOs with conflict retry and
//           anti-starvation hold. Optional same-cycle bypass: VRF_WB_BYPASS_EN.
// Rev     : 1.0  initial release
// ============================================================================
module vrf_wb_queue #(
  parameter int DEPTH        = 4,
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic               clk,
  input  logic               rstn,
  vrf_wb_queue_if.master     bus
);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_SW    = $clog2(STARVE_LIMIT + 1);

  logic                  r_run;
  logic [1:0]            w_fu_vld;
  logic [1:0]            w_fu_rdy;
  logic [1:0]            w_wr_vld;
  logic [1:0]            w_wr_conflict;
  logic [1:0]            w_hold;
  logic [1:0]            w_serve;
  logic [1:0]            w_at_limit;
  logic [1:0]            w_empty;
  logic                  w_idle;
  logic [ADDR_WIDTH-1:0] w_fu_waddr [2];
  logic [DATA_WIDTH-1:0] w_fu_wmask [2];
  logic [DATA_WIDTH-1:0] w_fu_wdata [2];
  logic [ADDR_WIDTH-1:0] w_waddr    [2];
  logic [DATA_WIDTH-1:0] w_wmask    [2];
  logic [DATA_WIDTH-1:0] w_wdata    [2];

  assign w_fu_vld      = {bus.fu1_vld, bus.fu0_vld};
  assign w_wr_conflict = {bus.wr1_conflict, bus.wr0_conflict};
  assign w_fu_waddr[0] = bus.fu0_waddr;
  assign w_fu_waddr[1] = bus.fu1_waddr;
  assign w_fu_wmask[0] = bus.fu0_wmask;
  assign w_fu_wmask[1] = bus.fu1_wmask;
  assign w_fu_wdata[0] = bus.fu0_wdata;
  assign w_fu_wdata[1] = bus.fu1_wdata;

  // Port 0 wins when both starve counters hit the limit together.
  assign w_hold[1]  = w_at_limit[0];
  assign w_hold[0]  = w_at_limit[1] & ~w_at_limit[0];
  assign w_serve[0] = w_hold[1];
  assign w_serve[1] = w_hold[0];

  // Keeps fuN_rdy low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_run <= 1'b0;
    else       r_run <= 1'b1;
  end

  for (genvar n = 0; n < 2; n++) begin : g_ch
    logic [ADDR_WIDTH-1:0] r_mem_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_mask [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_SW-1:0]       r_starve;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_enq;
    logic                  w_byp;

    assign w_empty[n]    = (r_count == '0);
    assign w_full        = (r_count == c_CNT_W'(DEPTH));
    assign w_at_limit[n] = (r_starve == c_SW'(STARVE_LIMIT));
    assign w_fu_rdy[n]   = r_run & ~w_full;
    assign w_push        = w_fu_vld[n] & w_fu_rdy[n];
`ifdef VRF_WB_BYPASS_EN
    assign w_byp         = w_empty[n] & w_push;
`else
    assign w_byp         = 1'b0;
`endif
    assign w_wr_vld[n]   = (~w_empty[n] | w_byp) & ~w_hold[n];
    assign w_pop         = w_wr_vld[n] & ~w_wr_conflict[n] & ~w_empty[n];
    // A bypassed write that lands cleanly never occupies a FIFO slot.
    assign w_enq         = w_push & ~(w_byp & w_wr_vld[n] & ~w_wr_conflict[n]);

    assign w_waddr[n] = w_byp ? w_fu_waddr[n] : (w_empty[n] ? '0 : r_mem_addr[r_rd_ptr]);
    assign w_wmask[n] = w_byp ? w_fu_wmask[n] : (w_empty[n] ? '0 : r_mem_mask[r_rd_ptr]);
    assign w_wdata[n] = w_byp ? w_fu_wdata[n] : (w_empty[n] ? '0 : r_mem_data[r_rd_ptr]);

    always_ff @(posedge clk) begin
      if (w_enq) begin
        r_mem_addr[r_wr_ptr] <= w_fu_waddr[n];
        r_mem_mask[r_wr_ptr] <= w_fu_wmask[n];
        r_mem_data[r_wr_ptr] <= w_fu_wdata[n];
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_starve <= '0;
      end else begin
        if (w_enq) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
        if (w_pop) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        r_count <= r_count + c_CNT_W'(w_enq) - c_CNT_W'(w_pop);
        // Serving cycle clears the counter even if the write conflicted again.
        if (w_empty[n] | w_pop | w_serve[n])
          r_starve <= '0;
        else if (w_wr_vld[n] & w_wr_conflict[n] & ~w_at_limit[n])
          r_starve <= r_starve + c_SW'(1);
      end
    end
  end

`ifdef VRF_WB_BYPASS_EN
  assign w_idle = (&w_empty) & ~(|w_fu_vld);
`else
  assign w_idle = &w_empty;
`endif

  assign bus.fu0_rdy     = w_fu_rdy[0];
  assign bus.fu1_rdy     = w_fu_rdy[1];
  assign bus.wr0_vld     = w_wr_vld[0];
  assign bus.wr1_vld     = w_wr_vld[1];
  assign bus.waddr0      = w_waddr[0];
  assign bus.wmask0      = w_wmask[0];
  assign bus.wdata0      = w_wdata[0];
  assign bus.waddr1      = w_waddr[1];
  assign bus.wmask1      = w_wmask[1];
  assign bus.wdata1      = w_wdata[1];
  assign bus.starve_hold = w_hold;
  assign bus.idle        = w_idle;
endmodule
`default_nettype wire

// File: tb/tb_vrf_wb_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_vrf_wb_queue
// Brief   : Directed self-checking bench for vrf_wb_queue
// Rev     : 1.0  initial release
// ============================================================================
module tb_vrf_wb_queue;
  logic clk;
  logic rstn;
  int   n_checks;
  int   n_fail;

  vrf_wb_queue_if #(.ADDR_WIDTH(5), .DATA_WIDTH(16)) bus ();

  vrf_wb_queue #(
    .DEPTH(4), .ADDR_WIDTH(5), .DATA_WIDTH(16), .STARVE_LIMIT(3)
  ) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.fu0_vld = 1'b0; bus.fu0_waddr = '0; bus.fu0_wmask = 16'hFFFF; bus.fu0_wdata = '0;
    bus.fu1_vld = 1'b0; bus.fu1_waddr = '0; bus.fu1_wmask = 16'hFFFF; bus.fu1_wdata = '0;
    bus.wr0_conflict = 1'b0;
    bus.wr1_conflict = 1'b0;
    rstn = 1'b1;
    #1 rstn = 1'b0;

    // Reset state
    #2;
    check_eq("rst_wr0_vld", bus.wr0_vld, 0);
    check_eq("rst_wr1_vld", bus.wr1_vld, 0);
    check_eq("rst_fu0_rdy", bus.fu0_rdy, 0);
    check_eq("rst_fu1_rdy", bus.fu1_rdy, 0);
    check_eq("rst_idle", bus.idle, 1);
    check_eq("rst_hold", bus.starve_hold, 0);
    check_eq("rst_waddr0", bus.waddr0, 0);
    check_eq("rst_wdata1", bus.wdata1, 0);
    cyc();
    rstn = 1'b1;
    cyc();
    #1;
    check_eq("rel_fu0_rdy", bus.fu0_rdy, 1);
    check_eq("rel_fu1_rdy", bus.fu1_rdy, 1);
    check_eq("rel_idle", bus.idle, 1);

`ifdef VRF_WB_BYPASS_EN
    // Bypass without conflict: same-cycle write, nothing enqueued
    bus.fu0_vld = 1'b1; bus.fu0_waddr = 5'h04; bus.fu0_wdata = 16'h1234;
    #1;
    check_eq("byp_vld", bus.wr0_vld, 1);
    check_eq("byp_data", bus.wdata0, 16'h1234);
    check_eq("byp_addr", bus.waddr0, 5'h04);
    check_eq("byp_idle_busy", bus.idle, 0);
    cyc();
    bus.fu0_vld = 1'b0;
    #1;
    check_eq("byp_after_vld", bus.wr0_vld, 0);
    check_eq("byp_after_idle", bus.idle, 1);
    // Bypass with conflict: enqueued and retried
    bus.fu0_vld = 1'b1; bus.fu0_waddr = 5'h05; bus.fu0_wdata = 16'h5678;
    bus.wr0_conflict = 1'b1;
    #1;
    check_eq("bypc_vld", bus.wr0_vld, 1);
    check_eq("bypc_data", bus.wdata0, 16'h5678);
    cyc();
    bus.fu0_vld = 1'b0; bus.wr0_conflict = 1'b0;
    #1;
    check_eq("bypc_retry_vld", bus.wr0_vld, 1);
    check_eq("bypc_retry_data", bus.wdata0, 16'h5678);
    check_eq("bypc_retry_addr", bus.waddr0, 5'h05);
    check_eq("bypc_idle", bus.idle, 0);
    cyc();
    #1;
    check_eq("bypc_done_idle", bus.idle, 1);
`else
    // Single write, no conflict
    bus.fu0_vld = 1'b1; bus.fu0_waddr = 5'h03; bus.fu0_wmask = 16'hFFFF; bus.fu0_wdata = 16'hA5A5;
    #1;
    check_eq("single_latency", bus.wr0_vld, 0);
    cyc();
    bus.fu0_vld = 1'b0;
    #1;
    check_eq("single_vld", bus.wr0_vld, 1);
    check_eq("single_addr", bus.waddr0, 5'h03);
    check_eq("single_mask", bus.wmask0, 16'hFFFF);
    check_eq("single_data", bus.wdata0, 16'hA5A5);
    check_eq("single_busy", bus.idle, 0);
    cyc();
    #1;
    check_eq("single_popped", bus.wr0_vld, 0);
    check_eq("single_idle", bus.idle, 1);

    // Conflict retry on channel 1
    bus.fu1_vld = 1'b1; bus.fu1_waddr = 5'h07; bus.fu1_wmask = 16'h00FF; bus.fu1_wdata = 16'h0707;
    cyc();
    bus.fu1_vld = 1'b0; bus.wr1_conflict = 1'b1;
    #1;
    check_eq("retry_c1_vld", bus.wr1_vld, 1);
    check_eq("retry_c1_addr", bus.waddr1, 5'h07);
    cyc();
    #1;
    check_eq("retry_c2_data", bus.wdata1, 16'h0707);
    check_eq("retry_c2_mask", bus.wmask1, 16'h00FF);
    cyc();
    bus.wr1_conflict = 1'b0;
    #1;
    check_eq("retry_c3_vld", bus.wr1_vld, 1);
    check_eq("retry_c3_addr", bus.waddr1, 5'h07);
    check_eq("retry_c3_hold", bus.starve_hold, 0);
    cyc();
    #1;
    check_eq("retry_popped", bus.wr1_vld, 0);
    check_eq("retry_idle", bus.idle, 1);

    // Fill to full under conflict, then drain in order
    bus.wr0_conflict = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.fu0_vld = 1'b1; bus.fu0_waddr = 5'(8 + i); bus.fu0_wdata = 16'(16'h1000 + i);
      cyc();
    end
    bus.fu0_waddr = 5'h1F; bus.fu0_wdata = 16'hFFFF;
    #1;
    check_eq("full_rdy", bus.fu0_rdy, 0);
    cyc();
    bus.fu0_vld = 1'b0; bus.wr0_conflict = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_vld", bus.wr0_vld, 1);
      check_eq("drain_addr", bus.waddr0, 32'(8 + i));
      check_eq("drain_data", bus.wdata0, 32'(16'h1000 + i));
      cyc();
      #1;
    end
    check_eq("full_rejected", bus.wr0_vld, 0);

    // Streaming across pointer wrap
    for (int j = 0; j < 6; j++) begin
      bus.fu0_vld = 1'b1; bus.fu0_waddr = 5'(16 + j); bus.fu0_wdata = 16'(16'h2000 + j);
      cyc();
      #1;
      check_eq("wrap_data", bus.wdata0, 32'(16'h2000 + j));
    end
    bus.fu0_vld = 1'b0;
    cyc();
    #1;
    check_eq("wrap_idle", bus.idle, 1);

    // Port 1 starves: port 0 held for one cycle
    bus.fu0_vld = 1'b1; bus.fu0_waddr = 5'h18; bus.fu0_wdata = 16'h3000;
    bus.fu1_vld = 1'b1; bus.fu1_waddr = 5'h02; bus.fu1_wdata = 16'h4444; bus.fu1_wmask = 16'hFFFF;
    cyc();
    bus.fu1_vld = 1'b0; bus.wr1_conflict = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.fu0_waddr = 5'(24 + i); bus.fu0_wdata = 16'(16'h3000 + i);
      #1;
      check_eq("starve_pre_hold", bus.starve_hold, 0);
      cyc();
    end
    bus.fu0_waddr = 5'h1C; bus.fu0_wdata = 16'h3004;
    bus.wr1_conflict = 1'b0;
    #1;
    check_eq("starve_hold", bus.starve_hold, 2'b01);
    check_eq("starve_wr0_vld", bus.wr0_vld, 0);
    check_eq("starve_wr1_vld", bus.wr1_vld, 1);
    check_eq("starve_waddr1", bus.waddr1, 5'h02);
    check_eq("starve_head0", bus.waddr0, 5'h1B);
    cyc();
    bus.fu0_vld = 1'b0;
    #1;
    check_eq("starve_after_hold", bus.starve_hold, 0);
    check_eq("starve_after_wr0", bus.wr0_vld, 1);
    check_eq("starve_after_head0", bus.waddr0, 5'h1B);
    check_eq("starve_after_wr1", bus.wr1_vld, 0);
    cyc();
    cyc();
    #1;
    check_eq("starve_idle", bus.idle, 1);

    // Simultaneous limit: port 1 held first, then port 0
    bus.fu0_vld = 1'b1; bus.fu0_waddr = 5'h0A; bus.fu0_wdata = 16'hAAAA;
    bus.fu1_vld = 1'b1; bus.fu1_waddr = 5'h0B; bus.fu1_wdata = 16'hBBBB;
    cyc();
    bus.fu0_vld = 1'b0; bus.fu1_vld = 1'b0;
    bus.wr0_conflict = 1'b1; bus.wr1_conflict = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("sim_pre_hold", bus.starve_hold, 0);
      cyc();
    end
    bus.wr0_conflict = 1'b0;
    #1;
    check_eq("sim_hold", bus.starve_hold, 2'b10);
    check_eq("sim_wr0_vld", bus.wr0_vld, 1);
    check_eq("sim_wr1_vld", bus.wr1_vld, 0);
    cyc();
    bus.wr1_conflict = 1'b0;
    #1;
    check_eq("sim_hold2", bus.starve_hold, 2'b01);
    check_eq("sim2_wr1_vld", bus.wr1_vld, 1);
    check_eq("sim2_wdata1", bus.wdata1, 16'hBBBB);
    check_eq("sim2_wr0_vld", bus.wr0_vld, 0);
    cyc();
    #1;
    check_eq("sim_idle", bus.idle, 1);
    check_eq("sim_hold_clear", bus.starve_hold, 0);
`endif

    // Reset with two entries queued
    bus.wr0_conflict = 1'b1;
    bus.fu0_vld = 1'b1; bus.fu0_waddr = 5'h11; bus.fu0_wdata = 16'h1111;
    cyc();
    bus.fu0_waddr = 5'h12; bus.fu0_wdata = 16'h2222;
    cyc();
    bus.fu0_vld = 1'b0;
    #1;
    check_eq("mid_pre_vld", bus.wr0_vld, 1);
    rstn = 1'b0;
    #1;
    check_eq("mid_rst_vld", bus.wr0_vld, 0);
    check_eq("mid_rst_rdy", bus.fu0_rdy, 0);
    check_eq("mid_rst_idle", bus.idle, 1);
    rstn = 1'b1;
    bus.wr0_conflict = 1'b0;
    cyc();
    #1;
    check_eq("mid_rel_rdy0", bus.fu0_rdy, 1);
    check_eq("mid_rel_rdy1", bus.fu1_rdy, 1);
    check_eq("mid_rel_idle", bus.idle, 1);
    check_eq("mid_rel_dropped", bus.wr0_vld, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
